// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter
//  A round-robin arbiter that shares one 4:1 mux datapath between four requesters
//  and feeds a single valid/ready output port.
//  The arbiter grants one owner at a time. A grant lasts for a burst of at most
//  MAX_BURST beats, and exactly one IDLE bubble cycle separates consecutive grants.
//  The registered owner index drives the mux select pins directly:
//      sel_s0 = owner bit 1, sel_s1 = owner bit 0.
//  Optional build macro PRIO_FIXED_EN selects fixed priority (req0 highest).
//  Fixed priority leaves the round-robin pointer frozen at 0.
module rr_mux4_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        gnt,
    output logic [3:0]        ack,
    output logic              sel_s0,
    output logic              sel_s1
);

    localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e            state_q;
    logic [3:0]        gnt_q;
    logic [1:0]        owner_q;
    logic [1:0]        ptr_q;
    logic [1:0]        ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q;

    logic [1:0]        winner_s;
    logic              owner_req_s;
    logic              valid_s;
    logic              beat_s;
    logic              release_s;
    logic [DATA_W-1:0] mux_data_s;

    // This function returns the first requester found by scanning start, start+1, ... modulo 4.
    // The 2-bit index wraps naturally, so no explicit modulo is needed.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // This block picks the next owner from the current search pointer.
    always_comb begin
        winner_s = rr_pick(req, ptr_q);
    end

    // This block computes the pointer loaded on release.
    // With fixed priority the pointer never leaves 0, so the search always starts at req0.
    always_comb begin
`ifdef PRIO_FIXED_EN
        ptr_d = ptr_q;
`else
        ptr_d = owner_q + 2'd1;
`endif
    end

    // This block handles the handshake qualification.
    // Valid is only meaningful while a grant is held.
    always_comb begin
        owner_req_s = req[owner_q];
        valid_s     = (state_q == ST_GRANT) && owner_req_s;
        beat_s      = valid_s && out_ready;
        release_s   = (!owner_req_s) || (beat_s && (beat_cnt_q == LAST_BEAT));
    end

    // This block steers the owner's data through the shared 4:1 mux.
    always_comb begin
        case (owner_q)
            2'd0:    mux_data_s = d0;
            2'd1:    mux_data_s = d1;
            2'd2:    mux_data_s = d2;
            2'd3:    mux_data_s = d3;
            default: mux_data_s = d0;
        endcase
    end

    // This block is the arbitration FSM: grant, burst counting and release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 4'b0000;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q    <= ST_GRANT;
                        gnt_q      <= 4'b0001 << winner_s;
                        owner_q    <= winner_s;
                        beat_cnt_q <= '0;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        // owner_q is kept so the mux select does not move while idle
                        state_q    <= ST_IDLE;
                        gnt_q      <= 4'b0000;
                        ptr_q      <= ptr_d;
                        beat_cnt_q <= '0;
                    end else if (beat_s) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end else begin
                        beat_cnt_q <= beat_cnt_q;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    gnt_q      <= 4'b0000;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

    assign out_valid = valid_s;
    assign out_data  = mux_data_s;
    assign gnt       = gnt_q;
    assign ack       = gnt_q & {4{beat_s}};
    assign sel_s0    = owner_q[1];
    assign sel_s1    = owner_q[0];

endmodule
